// File: rtl/edge_result_writer.sv
// edge_result_writer
//
// Packs the edge detector's per-window result byte pairs (final_out_1,
// final_out_2) two at a time into 32-bit words. Each finished word becomes a
// sequential memory write request. Each pair that is accepted returns a
// transfer_data_complete_w pulse, so the detector can fetch its next window.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     begins a frame (taken only in IDLE)
//   result_valid              final_out_1/2 valid this cycle
//   final_out_1, final_out_2  result byte pair
//   transfer_data_complete_w  one-cycle ack for an accepted pair
//   wr_req/wr_addr/wr_data    write request, held until wr_ack
//   wr_ack                    write accepted when high together with wr_req
//   busy                      state is not IDLE
//   frame_done                one-cycle pulse after the last word is written
//   overflow                  sticky: a pair was dropped (cleared by rst/start)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; result_valid ignored
// COLLECT | packing pairs into words, issuing writes
// DRAIN   | all frame bytes accepted; waiting for the last write to finish

module edge_result_writer #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int NUM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              result_valid,
    input  logic [7:0]        final_out_1,
    input  logic [7:0]        final_out_2,
    output logic              transfer_data_complete_w,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int CNT_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t            state_q;
    logic              half_q;
    logic [15:0]       lo_q;
    logic              pend_valid_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic              tdc_q;
    logic              frame_done_q;
    logic              overflow_q;

    logic              ack_take;
    logic              pend_free;
    logic [CNT_W-1:0]  byte_cnt_d;
    logic [ADDR_W-1:0] addr_d;

    assign ack_take   = pend_valid_q & wr_ack;
    // The pending slot can take a new word if it is empty or is being written now.
    assign pend_free  = ~pend_valid_q | wr_ack;
    assign byte_cnt_d = byte_cnt_q + CNT_W'(2);
    assign addr_d     = addr_q + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            half_q       <= 1'b0;
            lo_q         <= '0;
            pend_valid_q <= 1'b0;
            data_q       <= '0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            byte_cnt_q   <= '0;
            tdc_q        <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            tdc_q        <= 1'b0;
            frame_done_q <= 1'b0;

            if (ack_take) begin
                pend_valid_q <= 1'b0;
                addr_q       <= addr_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        half_q       <= 1'b0;
                        byte_cnt_q   <= '0;
                        pend_valid_q <= 1'b0;
                        overflow_q   <= 1'b0;
                        addr_q       <= ADDR_W'(BASE_ADDR);
                        state_q      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (result_valid) begin
                        if (!half_q) begin
                            lo_q       <= {final_out_2, final_out_1};
                            half_q     <= 1'b1;
                            byte_cnt_q <= byte_cnt_d;
                            tdc_q      <= 1'b1;
                            if (byte_cnt_d == CNT_W'(NUM_BYTES)) begin
                                state_q <= S_DRAIN;
                            end
                        end else if (pend_free) begin
                            // Overrides the ack clear above when a word completes on an ack cycle.
                            data_q       <= {final_out_2, final_out_1, lo_q};
                            pend_valid_q <= 1'b1;
                            half_q       <= 1'b0;
                            byte_cnt_q   <= byte_cnt_d;
                            tdc_q        <= 1'b1;
                            if (byte_cnt_d == CNT_W'(NUM_BYTES)) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pend_free) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign transfer_data_complete_w = tdc_q;
    assign wr_req                   = pend_valid_q;
    assign wr_addr                  = addr_q;
    assign wr_data                  = data_q;
    assign busy                     = (state_q != S_IDLE);
    assign frame_done               = frame_done_q;
    assign overflow                 = overflow_q;

endmodule
